mem_map_router: RTL
===================

# mem_map_router

Parametrised memory-map router between the CPU-side memory port and N memory-mapped targets (main memory, UART TX/RX, machine timer, future peripherals). It decodes each command against per-region base/mask parameters, forwards it to exactly one target with a region-relative address, and captures the target index at accept so that read data and valid are always returned from the target that actually accepted the command. An optional watchdog terminates reads that a target never answers, returning an error.

## Interface
Parameters:
- NUM_REGIONS, 4, number of targets (2..16); region 0 is the default (catch-all) target.
- REGION_BASE, {NUM_REGIONS{32'h0}}, packed [NUM_REGIONS*32-1:0]; base of region i in bits [32i+31:32i].
- REGION_MASK, {NUM_REGIONS{32'h0}}, packed as above; address bits compared for region i.
- TIMEOUT_CYCLES, 1024, watchdog limit in BUSY cycles (≥2); used only with MEMMAP_TIMEOUT_EN.
- ERROR_RDATA, 32'hDEADBEEF, read data returned on a timeout.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- input_cmd_start  in  1  command request.
- input_cmd_write  in  1  1 = write, 0 = read.
- input_addr  in  32  byte address.
- input_wdata  in  32  write data.
- output_cmd_ready  out  1  command accepted this cycle when high together with input_cmd_start.
- output_rdata  out  32  read data.
- output_rdata_valid  out  1  one-cycle read-completion strobe.
- output_error  out  1  high with output_rdata_valid on a timed-out read.
- dev_cmd_start  out  NUM_REGIONS  per-target start, one-hot or zero.
- dev_cmd_write  out  NUM_REGIONS  per-target write, gated like start.
- dev_addr  out  NUM_REGIONS*32  per-target address.
- dev_wdata  out  32  shared write data (= input_wdata).
- dev_cmd_ready  in  NUM_REGIONS  per-target ready.
- dev_rdata  in  NUM_REGIONS*32  per-target read data.
- dev_rdata_valid  in  NUM_REGIONS  per-target read valid.

## Operation
- Decode (combinational, on input_addr): region i (1..NUM_REGIONS-1) matches when (input_addr & MASK_i) == BASE_i; the lowest matching index wins; no match selects region 0.
- dev_addr[i] = input_addr − BASE_i for i ≥ 1 (32-bit modulo); dev_addr[0] = input_addr unmodified.
- dev_cmd_start[sel] = input_cmd_start && state==IDLE; all other bits 0. dev_cmd_write is gated identically.
- output_cmd_ready = (state==IDLE) && dev_cmd_ready[sel].
- FSM states: IDLE, BUSY.
  - IDLE, accepted write: stays in IDLE (posted write; no response).
  - IDLE, accepted read: tgt <= sel, state <= BUSY, timer <= 0.
  - BUSY: output_rdata = dev_rdata[tgt]; output_rdata_valid = dev_rdata_valid[tgt]; on that valid, state <= IDLE.
  - BUSY: dev_rdata_valid from any target ≠ tgt is ignored.
- In IDLE, output_rdata_valid = 0 and output_rdata = dev_rdata[tgt]. A stale or late valid is never forwarded.

## Timing
- Reset values: state IDLE, tgt 0, timer 0. output_rdata_valid 0, output_error 0, dev_cmd_start 0, output_rdata = dev_rdata[0].
- Decode, start and ready are zero-latency combinational paths from input_addr to target.
- Read completion is combinational from dev_rdata_valid[tgt]. The earliest next accept is the cycle after the completion cycle.
- Back-to-back posted writes are allowed every cycle the target is ready.
- If a target asserts rdata_valid in the same cycle as the read is accepted, that valid is ignored. The target's valid must arrive at accept+1 or later.
- Reset asserted mid-BUSY: immediate return to IDLE; the pending read is dropped with no response.

## Configuration
- MEMMAP_TIMEOUT_EN defined:
  - timer increments each BUSY cycle without a valid.
  - When timer reaches TIMEOUT_CYCLES−1 without a valid, that cycle drives output_rdata = ERROR_RDATA, output_rdata_valid = 1, output_error = 1, then goes to IDLE.
  - A valid arriving in the same cycle wins: normal data, output_error 0.
- MEMMAP_TIMEOUT_EN undefined: no timer; BUSY waits indefinitely; output_error tied 0.

## Test plan
- Configuration for all scenarios: NUM_REGIONS=4; BASE = {0, 0xF000_0000, 0xF000_0100, 0xFFFF_FF00}; MASK = {0, 0xFFFF_FF00, 0xFFFF_FF00, 0xFFFF_FF00}.
- Read 0xF000_0104 (region 2): dev_cmd_start=4'b0100, dev_addr[2]=0x4. Target returns 0x55 after 3 cycles → output_rdata_valid for 1 cycle with 0x55.
- Read to region 1, then a read to 0x0000_0040 presented in the completion cycle: no accept that cycle (ready 0). Accepted next cycle to region 0 with dev_addr[0]=0x40. Responses are never cross-routed.
- Spurious dev_rdata_valid[3] during a pending region-0 read → no output strobe; the real region-0 valid (0x1234) is forwarded.
- Three posted writes on consecutive cycles to 0x100, 0xF000_0000, 0x104 with all targets ready → three accepts, state stays IDLE, output_rdata_valid never asserted.
- MEMMAP_TIMEOUT_EN, TIMEOUT_CYCLES=8: read to a silent region 3 → valid + error + 0xDEADBEEF at accept+8, back to IDLE. A late valid is ignored. rst_n pulse mid-BUSY → IDLE with all outputs at reset values.

Source files
------------

// File: rtl/mem_map_router.sv
// Purpose: decode CPU memory commands onto one of NUM_REGIONS targets and route read data back from the accepting target.
// Latency: decode/start/ready are combinational; read completion is combinational from the target's rdata_valid.
// Backpressure: output_cmd_ready follows the selected target's ready while IDLE and is low while a read is pending.
//
// Ports: clk/rst_n (async active-low); input_* = CPU command side; output_* = CPU response side;
//        dev_* = per-target command/response buses, target i in slice [32i+31:32i] / bit i.
// Optional feature: define MEMMAP_TIMEOUT_EN to enable the read watchdog (TIMEOUT_CYCLES, ERROR_RDATA).
module mem_map_router #(
  parameter int                        NUM_REGIONS    = 4,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE    = {NUM_REGIONS{32'h0}},
  parameter logic [NUM_REGIONS*32-1:0] REGION_MASK    = {NUM_REGIONS{32'h0}},
  parameter int                        TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]               ERROR_RDATA    = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      input_cmd_start,
  input  logic                      input_cmd_write,
  input  logic [31:0]               input_addr,
  input  logic [31:0]               input_wdata,
  output logic                      output_cmd_ready,
  output logic [31:0]               output_rdata,
  output logic                      output_rdata_valid,
  output logic                      output_error,
  output logic [NUM_REGIONS-1:0]    dev_cmd_start,
  output logic [NUM_REGIONS-1:0]    dev_cmd_write,
  output logic [NUM_REGIONS*32-1:0] dev_addr,
  output logic [31:0]               dev_wdata,
  input  logic [NUM_REGIONS-1:0]    dev_cmd_ready,
  input  logic [NUM_REGIONS*32-1:0] dev_rdata,
  input  logic [NUM_REGIONS-1:0]    dev_rdata_valid
);

  localparam int SW = $clog2(NUM_REGIONS);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel;
  logic [SW-1:0] tgt_q, tgt_d;
  logic [31:0]   rdata_arr [NUM_REGIONS];

`ifdef MEMMAP_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  // Watchdog parameters have no function in this build.
  logic unused_cfg;
  assign unused_cfg = (^ERROR_RDATA) ^ (TIMEOUT_CYCLES == 0);
`endif

  // Scan downwards so the lowest matching region overwrites higher ones;
  // region 0 is never compared and is selected when nothing else hits.
  always_comb begin : decode
    sel = '0;
    for (int i = NUM_REGIONS - 1; i >= 1; i--) begin
      if ((input_addr & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]) begin
        sel = SW'(i);
      end
    end
  end

  // Region-relative addresses are offered to every target; only start is one-hot.
  genvar g;
  for (g = 0; g < NUM_REGIONS; g++) begin : g_region
    assign rdata_arr[g] = dev_rdata[g*32 +: 32];
    if (g == 0) begin : g_default
      assign dev_addr[31:0] = input_addr;
    end else begin : g_offset
      assign dev_addr[g*32 +: 32] = input_addr - REGION_BASE[g*32 +: 32];
    end
  end

  assign dev_wdata = input_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
`ifdef MEMMAP_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
`ifdef MEMMAP_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d            = state_q;
    tgt_d              = tgt_q;
`ifdef MEMMAP_TIMEOUT_EN
    timer_d            = timer_q;
`endif
    // Data always comes from the captured target so a stale valid from
    // another target can never be mistaken for the response.
    output_rdata       = rdata_arr[tgt_q];
    output_rdata_valid = 1'b0;
    output_error       = 1'b0;
    output_cmd_ready   = 1'b0;
    dev_cmd_start      = '0;
    dev_cmd_write      = '0;

    case (state_q)
      IDLE: begin
        output_cmd_ready   = dev_cmd_ready[sel];
        dev_cmd_start[sel] = input_cmd_start;
        dev_cmd_write[sel] = input_cmd_start & input_cmd_write;
        // Writes are posted and leave the FSM in IDLE; only reads wait.
        if (input_cmd_start && dev_cmd_ready[sel] && !input_cmd_write) begin
          state_d = BUSY;
          tgt_d   = sel;
`ifdef MEMMAP_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      BUSY: begin
        if (dev_rdata_valid[tgt_q]) begin
          output_rdata_valid = 1'b1;
          state_d            = IDLE;
`ifdef MEMMAP_TIMEOUT_EN
        end else if (timer_q == TIMER_LAST) begin
          // A real valid in the same cycle takes the branch above instead.
          output_rdata       = ERROR_RDATA;
          output_rdata_valid = 1'b1;
          output_error       = 1'b1;
          state_d            = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
